// File: rtl/axi_dot_master.sv
// Dot-product initiator: reads A[i] and B[i] over single-beat AXI-style reads, accumulates A*B,
// then writes the accumulator little-endian, one byte per write transaction.
module axi_dot_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_res,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            dbg_state
);

  localparam int NB  = ACC_WIDTH / DATA_WIDTH;
  localparam int K_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NB - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_A_ADDR = 4'd1;
  localparam logic [3:0] S_RD_A_DATA = 4'd2;
  localparam logic [3:0] S_RD_B_ADDR = 4'd3;
  localparam logic [3:0] S_RD_B_DATA = 4'd4;
  localparam logic [3:0] S_MAC       = 4'd5;
  localparam logic [3:0] S_WR_ADDR   = 4'd6;
  localparam logic [3:0] S_WR_DATA   = 4'd7;
  localparam logic [3:0] S_WR_RESP   = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  logic [3:0]              state;
  logic [ADDR_WIDTH-1:0]   base_a_r;
  logic [ADDR_WIDTH-1:0]   base_b_r;
  logic [ADDR_WIDTH-1:0]   base_res_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    idx;
  logic [LEN_WIDTH-1:0]    idx_nxt;
  logic [K_W-1:0]          k;
  logic [K_W-1:0]          k_nxt;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [ACC_WIDTH-1:0]    acc;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    mac_sum;

  assign prod    = {{DATA_WIDTH{1'b0}}, a_r} * {{DATA_WIDTH{1'b0}}, b_r};
  assign mac_sum = acc + ACC_WIDTH'(prod);
  assign idx_nxt = idx + LEN_WIDTH'(1);
  assign k_nxt   = k + K_W'(1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Every valid/ready here is decoded from the state alone, so it rises on state entry, stays
  // high with stable address/data until its handshake, and drops the cycle after.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign arvalid   = (state == S_RD_A_ADDR) || (state == S_RD_B_ADDR);
  assign rready    = (state == S_RD_A_DATA) || (state == S_RD_B_DATA);
  assign awvalid   = (state == S_WR_ADDR);
  assign wvalid    = (state == S_WR_DATA);
  assign bready    = (state == S_WR_RESP);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      base_a_r   <= '0;
      base_b_r   <= '0;
      base_res_r <= '0;
      len_r      <= '0;
      idx        <= '0;
      k          <= '0;
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      result     <= '0;
      araddr     <= '0;
      awaddr     <= '0;
      wdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_a_r   <= base_a;
            base_b_r   <= base_b;
            base_res_r <= base_res;
            len_r      <= len;
            acc        <= '0;
            idx        <= '0;
            k          <= '0;
            if (len == '0) begin
              awaddr <= base_res;
              wdata  <= '0;
              state  <= S_WR_ADDR;
            end else begin
              araddr <= base_a;
              state  <= S_RD_A_ADDR;
            end
          end
        end
        S_RD_A_ADDR: if (arready) state <= S_RD_A_DATA;
        S_RD_A_DATA: begin
          if (rvalid) begin
            a_r    <= rdata;
            araddr <= base_b_r + ADDR_WIDTH'(idx);
            state  <= S_RD_B_ADDR;
          end
        end
        S_RD_B_ADDR: if (arready) state <= S_RD_B_DATA;
        S_RD_B_DATA: begin
          if (rvalid) begin
            b_r   <= rdata;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= mac_sum;
          idx <= idx_nxt;
          if (idx == len_r - LEN_WIDTH'(1)) begin
            // Byte 0 comes straight from the new sum; acc is only updated at this same edge.
            awaddr <= base_res_r;
            wdata  <= mac_sum[DATA_WIDTH-1:0];
            state  <= S_WR_ADDR;
          end else begin
            araddr <= base_a_r + ADDR_WIDTH'(idx_nxt);
            state  <= S_RD_A_ADDR;
          end
        end
        S_WR_ADDR: if (awready) state <= S_WR_DATA;
        S_WR_DATA: if (wready) state <= S_WR_RESP;
        S_WR_RESP: begin
          if (bvalid) begin
            if (k == K_LAST) begin
              result <= acc;
              state  <= S_DONE;
            end else begin
              k      <= k_nxt;
              awaddr <= base_res_r + ADDR_WIDTH'(k_nxt);
              wdata  <= acc[int'(k_nxt)*DATA_WIDTH +: DATA_WIDTH];
              state  <= S_WR_ADDR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dot_master.sv
// Directed bench for axi_dot_master: a byte memory slave with optional random stalls that
// also watches handshake stability, plus one task per scenario.
module tb_axi_dot_master;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LW  = 8;
  localparam int ACW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_a, base_b, base_res;
  logic [LW-1:0] len;
  logic          busy, done;
  logic [ACW-1:0] result;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    dbg_state;

  always #5 clk = ~clk;

  axi_dot_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(ACW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_a(base_a), .base_b(base_b), .base_res(base_res), .len(len),
    .busy(busy), .done(done), .result(result),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .dbg_state(dbg_state)
  );

  logic [DW-1:0] mem [0:65535];
  logic [AW-1:0] ar_log[$];
  logic [AW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int viol = 0;
  int done_cnt = 0;
  int stall_en = 0;
  int rd_ph, rd_cnt, wr_ph, wr_cnt;
  logic [AW-1:0] rd_cap, wr_cap;
  logic [DW-1:0] wd_cap;

  function automatic int pick_stall();
    return (stall_en != 0) ? int'($urandom_range(0, 7)) : 0;
  endfunction

  // Slave: decides ready/valid at each falling edge for the next rising edge. Each pulse lasts
  // one cycle, and the master's valid/ready is already high when it is raised, so it always fires.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rd_ph = 0; wr_ph = 0; rd_cnt = 0; wr_cnt = 0;
    forever begin
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      if (!rst_n) begin
        rd_ph = 0;
        wr_ph = 0;
      end else begin
        if (done) done_cnt++;
        if (arvalid && awvalid) viol++;
        if (awvalid && wvalid) viol++;
        if (rd_ph == 4) rd_ph = 0;
        if (rd_ph == 2) begin rd_ph = 3; rd_cnt = pick_stall(); end
        if (rd_ph == 0 && arvalid) begin
          rd_ph = 1; rd_cap = araddr; rd_cnt = pick_stall(); ar_log.push_back(araddr);
        end
        if (rd_ph == 1) begin
          if (!arvalid || araddr !== rd_cap) viol++;
          if (rd_cnt == 0) begin arready = 1'b1; rd_ph = 2; end else rd_cnt--;
        end
        if (rd_ph == 3) begin
          if (!rready || arvalid || araddr !== rd_cap) viol++;
          if (rd_cnt == 0) begin rvalid = 1'b1; rdata = mem[rd_cap]; rd_ph = 4; end else rd_cnt--;
        end
        if (wr_ph == 6) wr_ph = 0;
        if (wr_ph == 2) begin wr_ph = 3; wr_cnt = pick_stall(); wd_cap = wdata; end
        if (wr_ph == 4) begin wr_ph = 5; wr_cnt = pick_stall(); end
        if (wr_ph == 0 && awvalid) begin wr_ph = 1; wr_cap = awaddr; wr_cnt = pick_stall(); end
        if (wr_ph == 1) begin
          if (!awvalid || awaddr !== wr_cap) viol++;
          if (wr_cnt == 0) begin awready = 1'b1; wr_ph = 2; end else wr_cnt--;
        end
        if (wr_ph == 3) begin
          if (!wvalid || awvalid || awaddr !== wr_cap || wdata !== wd_cap) viol++;
          if (wr_cnt == 0) begin wready = 1'b1; wr_ph = 4; end else wr_cnt--;
        end
        if (wr_ph == 5) begin
          if (!bready || wvalid || awaddr !== wr_cap || wdata !== wd_cap) viol++;
          if (wr_cnt == 0) begin bvalid = 1'b1; mem[wr_cap] = wd_cap; wr_ph = 6; end else wr_cnt--;
        end
      end
    end
  end

  // Starts one command, scrambles the command inputs, optionally pokes start while busy, waits for done.
  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] r,
                        input logic [LW-1:0] n, input bit poke, output bit timed_out);
    @(negedge clk);
    base_a = a; base_b = b; base_res = r; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_a = 16'hDEAD; base_b = 16'hBEEF; base_res = 16'h0BAD; len = 8'd7;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin timed_out = 1'b0; break; end
      start = (poke && (cyc == 4 || cyc == 11)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_res(input logic [AW-1:0] r);
    for (int i = 0; i < 4; i++) mem[AW'(r + AW'(i))] = 8'hAA;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if ({busy, done, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done, awvalid, wvalid, bready, arvalid, rready});
    end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %h expected 0", result); end
    total++; if (awaddr !== '0 || araddr !== '0) begin
      bad++; $display("FAIL reset_addr: got aw=%h ar=%h expected 0", awaddr, araddr);
    end
    total++; if (wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    total++; if (dbg_state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [AW-1:0] r, input string tag);
    bit to;
    int d0;
    logic [31:0] rb;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[256] = 8'h04; mem[257] = 8'h05; mem[258] = 8'h06;
    fill_res(r);
    ar_log.delete();
    exp_q.delete();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0102);
    d0 = done_cnt;
    run_op(16'h0000, 16'h0100, r, 8'd3, (stall_en != 0), to);
    rb = {mem[r+16'd3], mem[r+16'd2], mem[r+16'd1], mem[r]};
    total++; if (to) begin bad++; $display("FAIL %s_timeout: got no done expected done", tag); end
    total++; if (result !== 32'h20) begin bad++; $display("FAIL %s_result: got %h expected 00000020", tag, result); end
    total++; if (rb !== 32'h00000020) begin bad++; $display("FAIL %s_mem: got %h expected 00000020", tag, rb); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy: got %b expected 0", tag, busy); end
    total++; if (ar_log.size() !== exp_q.size()) begin
      bad++; $display("FAIL %s_ar_count: got %0d expected %0d", tag, ar_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ar_log.size(); i++) begin
      total++; if (ar_log[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s_ar_addr[%0d]: got %h expected %h", tag, i, ar_log[i], exp_q[i]);
      end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL %s_protocol: got %0d violations expected 0", tag, viol); end
  endtask

  task automatic test_len_zero();
    bit to;
    int d0;
    logic [31:0] rb;
    fill_res(16'h0300);
    ar_log.delete();
    d0 = done_cnt;
    run_op(16'h0000, 16'h0100, 16'h0300, 8'd0, 1'b0, to);
    rb = {mem[16'h0303], mem[16'h0302], mem[16'h0301], mem[16'h0300]};
    total++; if (to) begin bad++; $display("FAIL len0_timeout: got no done expected done"); end
    total++; if (ar_log.size() !== 0) begin bad++; $display("FAIL len0_ar_count: got %0d expected 0", ar_log.size()); end
    total++; if (rb !== 32'h0) begin bad++; $display("FAIL len0_mem: got %h expected 00000000", rb); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL len0_result: got %h expected 00000000", result); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL len0_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_saturate();
    bit to;
    logic [31:0] rb;
    for (int i = 0; i < 4; i++) begin
      mem[16'h1000 + AW'(i)] = 8'hFF;
      mem[16'h2000 + AW'(i)] = 8'hFF;
    end
    fill_res(16'h0400);
    run_op(16'h1000, 16'h2000, 16'h0400, 8'd4, 1'b0, to);
    rb = {mem[16'h0403], mem[16'h0402], mem[16'h0401], mem[16'h0400]};
    total++; if (to) begin bad++; $display("FAIL ff_timeout: got no done expected done"); end
    total++; if (result !== 32'h0003F804) begin bad++; $display("FAIL ff_result: got %h expected 0003f804", result); end
    total++; if (rb !== 32'h0003F804) begin bad++; $display("FAIL ff_mem: got %h expected 0003f804", rb); end
  endtask

  task automatic test_wrap_and_abort();
    bit to;
    int n_ar;
    bit seen;
    logic [31:0] rb;
    mem[16'hFFFF] = 8'h03; mem[16'h0000] = 8'h01;
    mem[16'h3000] = 8'h02; mem[16'h3001] = 8'h05;
    fill_res(16'h0600);
    ar_log.delete();
    exp_q.delete();
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h3000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h3001);
    run_op(16'hFFFF, 16'h3000, 16'h0600, 8'd2, 1'b0, to);
    rb = {mem[16'h0603], mem[16'h0602], mem[16'h0601], mem[16'h0600]};
    total++; if (to) begin bad++; $display("FAIL wrap_timeout: got no done expected done"); end
    total++; if (result !== 32'd11) begin bad++; $display("FAIL wrap_result: got %h expected 0000000b", result); end
    total++; if (rb !== 32'd11) begin bad++; $display("FAIL wrap_mem: got %h expected 0000000b", rb); end
    total++; if (ar_log.size() !== exp_q.size()) begin
      bad++; $display("FAIL wrap_ar_count: got %0d expected %0d", ar_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ar_log.size(); i++) begin
      total++; if (ar_log[i] !== exp_q[i]) begin
        bad++; $display("FAIL wrap_ar_addr[%0d]: got %h expected %h", i, ar_log[i], exp_q[i]);
      end
    end
    // Start the basic job and abort it while the B read is outstanding.
    @(negedge clk);
    base_a = 16'h0000; base_b = 16'h0100; base_res = 16'h0700; len = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (dbg_state == 4'd4) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_reach_rd_b_data: got state %0d expected 4", dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
      bad++; $display("FAIL abort_ctrl: got %b expected 0000000", {busy, done, awvalid, wvalid, bready, arvalid, rready});
    end
    total++; if (araddr !== '0 || result !== '0 || dbg_state !== 4'd0) begin
      bad++; $display("FAIL abort_regs: got ar=%h res=%h st=%0d expected 0 0 0", araddr, result, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_ar = ar_log.size();
    repeat (6) @(negedge clk);
    total++; if (ar_log.size() !== n_ar || busy !== 1'b0) begin
      bad++; $display("FAIL abort_no_resume: got %0d new reads busy=%b expected 0 reads busy=0", ar_log.size() - n_ar, busy);
    end
  endtask

  initial begin
    start = 1'b0; base_a = '0; base_b = '0; base_res = '0; len = '0;
    test_reset();
    test_basic(16'h0200, "basic");
    test_len_zero();
    test_saturate();
    stall_en = 1;
    test_basic(16'h0500, "stall");
    stall_en = 0;
    test_wrap_and_abort();
    test_basic(16'h0700, "rerun");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
